// File: rtl/raw_data_in_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : raw_data_in_fifo
//  Description : Synchronous FIFO for raw data words. Each entry stores a
//                data word, an index tag and its byte strobes as one unit.
//                The head entry is presented on registered outputs one cycle
//                after an accepted pop and is held until the next pop.
//                Occupancy is tracked by an explicit count register.
//  Revision    : 1.0 - initial release
// ============================================================================
module raw_data_in_fifo #(
    parameter int DATA_W  = 128,
    parameter int INDEX_W = 8,
    parameter int DEPTH   = 16,
    parameter int AW      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  push,
    input  logic [DATA_W-1:0]     push_data,
    input  logic [INDEX_W-1:0]    push_index,
    input  logic [DATA_W/8-1:0]   push_wstrb,
    input  logic                  pop,
    output logic [DATA_W-1:0]     pop_data,
    output logic [INDEX_W-1:0]    pop_index,
    output logic [DATA_W/8-1:0]   pop_wstrb,
    output logic                  empty,
    output logic                  full,
    output logic [AW:0]           count,
    output logic                  overflow
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int          c_STRB_W    = DATA_W / 8;
    localparam int          c_ENTRY_W   = DATA_W + INDEX_W + c_STRB_W;
    localparam logic [AW:0] c_DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] c_CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] c_PTR_ONE = AW'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    // Entry layout: {data, index, wstrb} packed together so the three fields
    // can never drift apart across entries.
    logic [c_ENTRY_W-1:0] r_mem [DEPTH];

    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW:0]          r_count;
    logic [DATA_W-1:0]    r_pop_data;
    logic [INDEX_W-1:0]   r_pop_index;
    logic [c_STRB_W-1:0]  r_pop_wstrb;
    logic                 r_overflow;

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop_acc;
    logic                 w_push_acc;
    logic                 w_push_drop;
    logic [c_ENTRY_W-1:0] w_push_entry;
    logic [c_ENTRY_W-1:0] w_head_entry;

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == c_DEPTH_CNT);

    // A pop is only honoured when there is something stored; a pop on an
    // empty FIFO is silently ignored (no error flag).
    assign w_pop_acc    = pop & ~w_empty;

    // A push into a full FIFO still succeeds when the same cycle frees a slot.
    assign w_push_acc   = push & (~w_full | w_pop_acc);
    assign w_push_drop  = push & ~w_push_acc;

    assign w_push_entry = {push_data, push_index, push_wstrb};
    assign w_head_entry = r_mem[r_rd_ptr];

    // Storage write; the array itself is deliberately left unreset because
    // nothing reads it until a push has been accepted.
    always_ff @(posedge clk) begin
        if (!reset && !clr && w_push_acc) begin
            r_mem[r_wr_ptr] <= w_push_entry;
        end
    end

    // Write pointer: advances on every accepted push, wraps modulo DEPTH.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_wr_ptr <= '0;
        end else if (w_push_acc) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
        end
    end

    // Read pointer: advances on every accepted pop, wraps modulo DEPTH.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_rd_ptr <= '0;
        end else if (w_pop_acc) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
    end

    // Occupancy count: moves by at most one per cycle, holds on push+pop.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_count <= '0;
        end else begin
            case ({w_push_acc, w_pop_acc})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Registered head outputs: loaded from the head slot on an accepted pop
    // and otherwise held (no first-word fall-through).
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_pop_data  <= '0;
            r_pop_index <= '0;
            r_pop_wstrb <= '0;
        end else if (w_pop_acc) begin
            r_pop_data  <= w_head_entry[c_ENTRY_W-1 -: DATA_W];
            r_pop_index <= w_head_entry[c_STRB_W +: INDEX_W];
            r_pop_wstrb <= w_head_entry[0 +: c_STRB_W];
        end
    end

    // Sticky overflow: set by any dropped push, cleared only by reset or clr.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_overflow <= 1'b0;
        end else if (w_push_drop) begin
            r_overflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign pop_data  = r_pop_data;
    assign pop_index = r_pop_index;
    assign pop_wstrb = r_pop_wstrb;
    assign empty     = w_empty;
    assign full      = w_full;
    assign count     = r_count;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_raw_data_in_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_raw_data_in_fifo
//  Description : Scoreboard bench for raw_data_in_fifo. A queue-based model
//                predicts the post-edge outputs of every cycle; a separate
//                monitor compares them against the DUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_raw_data_in_fifo;

    localparam int DATA_W  = 128;
    localparam int INDEX_W = 8;
    localparam int DEPTH   = 16;
    localparam int AW      = 4;
    localparam int STRB_W  = DATA_W / 8;

    typedef struct packed {
        logic [DATA_W-1:0]  d;
        logic [INDEX_W-1:0] i;
        logic [STRB_W-1:0]  s;
    } ent_t;

    typedef struct packed {
        ent_t        out;
        logic [AW:0] cnt;
        logic        emp;
        logic        ful;
        logic        ovf;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                clr = 1'b0;
    logic                push = 1'b0;
    logic [DATA_W-1:0]   push_data = '0;
    logic [INDEX_W-1:0]  push_index = '0;
    logic [STRB_W-1:0]   push_wstrb = '0;
    logic                pop = 1'b0;
    logic [DATA_W-1:0]   pop_data;
    logic [INDEX_W-1:0]  pop_index;
    logic [STRB_W-1:0]   pop_wstrb;
    logic                empty;
    logic                full;
    logic [AW:0]         count;
    logic                overflow;

    raw_data_in_fifo #(
        .DATA_W (DATA_W),
        .INDEX_W(INDEX_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .push      (push),
        .push_data (push_data),
        .push_index(push_index),
        .push_wstrb(push_wstrb),
        .pop       (pop),
        .pop_data  (pop_data),
        .pop_index (pop_index),
        .pop_wstrb (pop_wstrb),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Reference model state
    ent_t m_q[$];
    ent_t m_out;
    bit   m_ovf;
    exp_t exp_q[$];

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    function automatic logic [DATA_W-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Apply one cycle of stimulus and record the predicted post-edge state.
    task automatic step(input bit r, input bit c, input bit pu, input bit po,
                        input logic [DATA_W-1:0] d, input logic [INDEX_W-1:0] ix,
                        input logic [STRB_W-1:0] s);
        bit   pop_ok;
        bit   push_ok;
        exp_t e;
        @(negedge clk);
        reset = r; clr = c; push = pu; pop = po;
        push_data = d; push_index = ix; push_wstrb = s;
        if (r || c) begin
            m_q.delete();
            m_out = '0;
            m_ovf = 1'b0;
        end else begin
            pop_ok  = po && (m_q.size() > 0);
            push_ok = pu && ((m_q.size() < DEPTH) || pop_ok);
            if (pop_ok)  m_out = m_q.pop_front();
            if (push_ok) m_q.push_back('{d: d, i: ix, s: s});
            if (pu && !push_ok) m_ovf = 1'b1;
        end
        e.out = m_out;
        e.cnt = (AW+1)'(m_q.size());
        e.emp = (m_q.size() == 0);
        e.ful = (m_q.size() == DEPTH);
        e.ovf = m_ovf;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, '0, '0, '0);
    endtask

    task automatic do_push(input logic [DATA_W-1:0] d, input logic [INDEX_W-1:0] ix,
                           input logic [STRB_W-1:0] s);
        step(0, 0, 1, 0, d, ix, s);
    endtask

    task automatic do_pop();
        step(0, 0, 0, 1, '0, '0, '0);
    endtask

    // Monitor: one comparison per clock edge, decoupled from the stimulus.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (pop_data !== e.out.d || pop_index !== e.out.i ||
                    pop_wstrb !== e.out.s || count !== e.cnt ||
                    empty !== e.emp || full !== e.ful || overflow !== e.ovf) begin
                    miscompares++;
                    $display("FAIL cycle%0d outputs: got data=%h idx=%h strb=%h cnt=%0d empty=%b full=%b ovf=%b; want data=%h idx=%h strb=%h cnt=%0d empty=%b full=%b ovf=%b",
                             cyc, pop_data, pop_index, pop_wstrb, count, empty, full, overflow,
                             e.out.d, e.out.i, e.out.s, e.cnt, e.emp, e.ful, e.ovf);
                end
            end
        end
    end

    initial begin
        bit pu;
        bit po;
        m_out = '0;
        m_ovf = 1'b0;

        // Reset state
        step(1, 0, 0, 0, '0, '0, '0);
        step(1, 0, 0, 0, '0, '0, '0);

        // Single push then pop
        do_push({4{32'hAAAA_AAAA}}, 8'h01, 16'hFFFF);
        do_pop();
        idle();

        // Fill, overflow, drain in order; extra pops on empty are ignored
        for (int k = 0; k < DEPTH; k++) do_push(rnd_data(), 8'(k), 16'($urandom));
        do_push(rnd_data(), 8'h10, 16'hFFFF);
        for (int k = 0; k < DEPTH + 2; k++) do_pop();
        step(0, 1, 0, 0, '0, '0, '0);

        // Push+pop at full
        for (int k = 0; k < DEPTH; k++) do_push(rnd_data(), 8'(k), 16'($urandom));
        step(0, 0, 1, 1, rnd_data(), 8'h20, 16'h00FF);
        for (int k = 0; k < DEPTH; k++) do_pop();

        // Pop held high while empty, then a single push
        step(1, 0, 0, 0, '0, '0, '0);
        for (int k = 0; k < 40; k++) do_pop();
        step(0, 0, 1, 1, rnd_data(), 8'h05, 16'h1234);
        for (int k = 0; k < 4; k++) do_pop();

        // Wrap-around with a steady occupancy of 8
        for (int k = 0; k < 8; k++) do_push(rnd_data(), 8'(100 + k), 16'($urandom));
        for (int k = 0; k < 10; k++) step(0, 0, 1, 1, rnd_data(), 8'(k), 16'($urandom));
        for (int k = 0; k < 8; k++) do_pop();

        // clr with push and pop pending, five entries stored and overflow set
        for (int k = 0; k < DEPTH; k++) do_push(rnd_data(), 8'(k), 16'($urandom));
        do_push(rnd_data(), 8'hEE, 16'hFFFF);
        for (int k = 0; k < DEPTH - 5; k++) do_pop();
        step(0, 1, 1, 1, rnd_data(), 8'h77, 16'hFFFF);
        do_pop();
        idle();

        // Randomized traffic with occasional clr and reset
        for (int k = 0; k < 800; k++) begin
            pu = ($urandom_range(0, 99) < ((k / 200) % 2 == 0 ? 70 : 35));
            po = ($urandom_range(0, 99) < ((k / 200) % 2 == 0 ? 35 : 70));
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 79) == 0),
                 pu, po, rnd_data(), 8'($urandom), 16'($urandom));
        end
        idle();

        // Let the monitor drain the scoreboard, bounded
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending vectors, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
